// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Arbitrates two requesters onto one combinational ALU and
//               registers the result into a one-entry tagged response slot.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 5,
  parameter int FAIR   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [2*CTL_W-1:0]   i_req_ctl,
  input  logic [2*DATA_W-1:0]  i_req_a,
  input  logic [2*DATA_W-1:0]  i_req_b,
  output logic [CTL_W-1:0]     o_alu_ctl,
  output logic [DATA_W-1:0]    o_alu_in1,
  output logic [DATA_W-1:0]    o_alu_in2,
  input  logic [DATA_W-1:0]    i_alu_out,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic                 o_rsp_id,
  output logic [DATA_W-1:0]    o_rsp_data
);

  localparam logic [CTL_W-1:0] c_CTL_ADD = CTL_W'(5'b00010);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                w_can_issue;
  logic                w_grant;
  logic                w_grant_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_EMPTY;
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last_grant <= w_grant_idx;
        r_rsp_id     <= w_grant_idx;
        r_rsp_data   <= i_alu_out;
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is half-accepted.
  always_comb begin
    w_can_issue = (r_state == S_EMPTY) | i_rsp_ready;
    w_grant     = 1'b0;
    w_grant_idx = 1'b0;
    if (w_can_issue && !reset) begin
      case (i_req_valid)
        2'b01: begin
          w_grant     = 1'b1;
          w_grant_idx = 1'b0;
        end
        2'b10: begin
          w_grant     = 1'b1;
          w_grant_idx = 1'b1;
        end
        2'b11: begin
          w_grant     = 1'b1;
          w_grant_idx = (FAIR != 0) ? ~r_last_grant : 1'b0;
        end
        default: begin
          w_grant     = 1'b0;
          w_grant_idx = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 2'b00;
    o_alu_ctl   = c_CTL_ADD;
    o_alu_in1   = '0;
    o_alu_in2   = '0;
    if (w_grant) begin
      w_state_nxt = S_FULL;
      o_req_ready = w_grant_idx ? 2'b10 : 2'b01;
      o_alu_ctl   = w_grant_idx ? i_req_ctl[CTL_W +: CTL_W]   : i_req_ctl[0 +: CTL_W];
      o_alu_in1   = w_grant_idx ? i_req_a[DATA_W +: DATA_W]   : i_req_a[0 +: DATA_W];
      o_alu_in2   = w_grant_idx ? i_req_b[DATA_W +: DATA_W]   : i_req_b[0 +: DATA_W];
    end else if (r_state == S_FULL && i_rsp_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  assign o_rsp_valid = (r_state == S_FULL);
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Bench for alu_share_arbiter; a round-robin and a fixed-priority
//               instance checked each cycle against a behavioural slot model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 5;
  localparam logic [CW-1:0] ADD  = 5'b00010;
  localparam logic [CW-1:0] SUB  = 5'b00110;
  localparam logic [CW-1:0] ANDC = 5'b00000;
  localparam logic [CW-1:0] SLT  = 5'b00111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // index 0: FAIR=1 instance, index 1: FAIR=0 instance
  logic [1:0]      t_valid [2];
  logic            t_rr    [2];
  logic [2*CW-1:0] t_ctl   [2];
  logic [2*DW-1:0] t_a     [2];
  logic [2*DW-1:0] t_b     [2];
  logic [1:0]      o_ready [2];
  logic [CW-1:0]   o_ctl   [2];
  logic [DW-1:0]   o_in1   [2];
  logic [DW-1:0]   o_in2   [2];
  logic [DW-1:0]   alu_out [2];
  logic            o_rv    [2];
  logic            o_rid   [2];
  logic [DW-1:0]   o_rdata [2];

  function automatic logic [DW-1:0] alu_f(logic [CW-1:0] c, logic [DW-1:0] a, logic [DW-1:0] b);
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      ANDC:    return a & b;
      SLT:     return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return a | b;
    endcase
  endfunction

  assign alu_out[0] = alu_f(o_ctl[0], o_in1[0], o_in2[0]);
  assign alu_out[1] = alu_f(o_ctl[1], o_in1[1], o_in2[1]);

  alu_share_arbiter #(.DATA_W(DW), .CTL_W(CW), .FAIR(1)) u_rr (
    .clk(clk), .reset(reset),
    .i_req_valid(t_valid[0]), .o_req_ready(o_ready[0]),
    .i_req_ctl(t_ctl[0]), .i_req_a(t_a[0]), .i_req_b(t_b[0]),
    .o_alu_ctl(o_ctl[0]), .o_alu_in1(o_in1[0]), .o_alu_in2(o_in2[0]),
    .i_alu_out(alu_out[0]),
    .o_rsp_valid(o_rv[0]), .i_rsp_ready(t_rr[0]),
    .o_rsp_id(o_rid[0]), .o_rsp_data(o_rdata[0])
  );

  alu_share_arbiter #(.DATA_W(DW), .CTL_W(CW), .FAIR(0)) u_fp (
    .clk(clk), .reset(reset),
    .i_req_valid(t_valid[1]), .o_req_ready(o_ready[1]),
    .i_req_ctl(t_ctl[1]), .i_req_a(t_a[1]), .i_req_b(t_b[1]),
    .o_alu_ctl(o_ctl[1]), .o_alu_in1(o_in1[1]), .o_alu_in2(o_in2[1]),
    .i_alu_out(alu_out[1]),
    .o_rsp_valid(o_rv[1]), .i_rsp_ready(t_rr[1]),
    .o_rsp_id(o_rid[1]), .o_rsp_data(o_rdata[1])
  );

  // Behavioural model of each instance's response slot
  bit            m_full [2];
  bit            m_id   [2];
  logic [DW-1:0] m_data [2];
  bit            m_last [2];
  int            eg     [2];
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(string tag, int m, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  function automatic int grant_of(int m, logic [1:0] v, logic rr, logic rst);
    if (rst) return -1;
    if (m_full[m] && !rr) return -1;
    case (v)
      2'b01:   return 0;
      2'b10:   return 1;
      2'b11:   return (m == 1) ? 0 : (m_last[m] ? 0 : 1);
      default: return -1;
    endcase
  endfunction

  // Inputs are applied at the falling edge; this checks that cycle and the next edge.
  task automatic cycle();
    logic [CW-1:0] ec;
    logic [DW-1:0] ea, eb;
    #1;
    for (int m = 0; m < 2; m++) begin
      eg[m] = grant_of(m, t_valid[m], t_rr[m], reset);
      ec = ADD; ea = '0; eb = '0;
      if (eg[m] >= 0) begin
        ec = t_ctl[m][eg[m]*CW +: CW];
        ea = t_a[m][eg[m]*DW +: DW];
        eb = t_b[m][eg[m]*DW +: DW];
      end
      chk("req_ready", m, 64'(o_ready[m]), (eg[m] < 0) ? 64'd0 : ((eg[m] == 1) ? 64'd2 : 64'd1));
      chk("alu_ctl", m, 64'(o_ctl[m]), 64'(ec));
      chk("alu_in1", m, 64'(o_in1[m]), 64'(ea));
      chk("alu_in2", m, 64'(o_in2[m]), 64'(eb));
      if (reset) begin
        m_full[m] = 0; m_id[m] = 0; m_data[m] = '0; m_last[m] = 1;
      end else if (eg[m] >= 0) begin
        m_full[m] = 1; m_id[m] = (eg[m] == 1); m_data[m] = alu_f(ec, ea, eb); m_last[m] = (eg[m] == 1);
      end else if (t_rr[m]) begin
        m_full[m] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rsp_valid", m, 64'(o_rv[m]), 64'(m_full[m]));
      chk("rsp_id", m, 64'(o_rid[m]), 64'(m_id[m]));
      chk("rsp_data", m, 64'(o_rdata[m]), 64'(m_data[m]));
    end
    @(negedge clk);
  endtask

  task automatic drive(logic [1:0] v, logic rr, logic [CW-1:0] c0, logic [DW-1:0] a0, logic [DW-1:0] b0,
                       logic [CW-1:0] c1, logic [DW-1:0] a1, logic [DW-1:0] b1);
    for (int m = 0; m < 2; m++) begin
      t_valid[m] = v;
      t_rr[m]    = rr;
      t_ctl[m]   = {c1, c0};
      t_a[m]     = {a1, a0};
      t_b[m]     = {b1, b0};
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_full[m] = 1; m_id[m] = 0; m_data[m] = '0; m_last[m] = 1; eg[m] = -1;
    end
    drive(2'b11, 1'b1, ADD, 1, 1, ADD, 2, 2);
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;

    // Contention from reset: round-robin alternates, fixed priority keeps req 0
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1'b1, ADD, DW'(k), 10, SUB, 100, DW'(k));
      cycle();
      chk("rr_seq_id", 0, 64'(o_rid[0]), 64'(k % 2));
      chk("fp_seq_id", 1, 64'(o_rid[1]), 64'd0);
    end

    // Idle cycle drains the slot
    drive(2'b00, 1'b1, SUB, 3, 3, SUB, 4, 4);
    cycle();
    chk("idle_drain", 0, 64'(o_rv[0]), 64'd0);

    // Single requester: 5 + 7
    drive(2'b01, 1'b1, ADD, 5, 7, ADD, 0, 0);
    cycle();
    chk("add_data", 0, 64'(o_rdata[0]), 64'd12);
    chk("add_id", 0, 64'(o_rid[0]), 64'd0);

    // Backpressure: SUB 9-4 held while req 1 waits
    drive(2'b01, 1'b1, SUB, 9, 4, ADD, 0, 0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 1'b0, SUB, 9, 4, ANDC, 32'hF0F0, 32'h0FF0);
      cycle();
      chk("bp_hold", 0, 64'(o_rdata[0]), 64'd5);
    end
    drive(2'b10, 1'b1, SUB, 9, 4, ANDC, 32'hF0F0, 32'h0FF0);
    cycle();
    chk("bp_refill_id", 0, 64'(o_rid[0]), 64'd1);
    chk("bp_refill_data", 0, 64'(o_rdata[0]), 64'h00F0);

    // Reset with a held response, then first contention goes to req 0
    drive(2'b11, 1'b0, SLT, 32'hFFFF_FFFF, 1, ADD, 1, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_clear", 0, 64'(o_rv[0]), 64'd0);
    drive(2'b11, 1'b1, SLT, 32'hFFFF_FFFF, 1, ADD, 1, 1);
    cycle();
    chk("post_rst_id", 0, 64'(o_rid[0]), 64'd0);
    chk("post_rst_slt", 0, 64'(o_rdata[0]), 64'd1);

    // Randomized traffic; an unaccepted request holds its fields
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 2; i++) begin
          if (!(t_valid[m][i] && eg[m] != i)) begin
            logic [CW-1:0] c;
            case ($urandom_range(0, 3))
              0: c = ADD;
              1: c = SUB;
              2: c = ANDC;
              default: c = SLT;
            endcase
            t_valid[m][i]        = ($urandom_range(0, 9) < 6);
            t_ctl[m][i*CW +: CW] = c;
            t_a[m][i*DW +: DW]   = $urandom;
            t_b[m][i*DW +: DW]   = $urandom;
          end
        end
        t_rr[m] = ($urandom_range(0, 9) < 7);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
